// File: rtl/mem_resp_multi.sv
// mem_resp_multi: multicycle memory responder between a multicycle CPU
// control path and a synchronous single-port SRAM (read data one cycle after
// the address). A level request is accepted in IDLE. It then passes through
// WAIT_CYCLES wait states, one SRAM ACCESS cycle and one RESP cycle that
// pulses oReady. RELEASE then waits for the request to drop, so a held
// request is serviced only once.
//
// Ports:
//   iCLK, iRST        clock, synchronous active-high reset
//   iMemRead/Write    level requests (both high is an error)
//   iAddress          byte address, latched at acceptance
//   iWriteData        store data, latched at acceptance
//   iByteEn           store byte-lane enables, latched at acceptance
//   oReadData         registered load data, held until the next read completes
//   oReady, oErr      one-cycle completion / error pulses (oErr only with oReady)
//   oBusy             high in every state except IDLE
//   oSramAddr/We/Be/WData, iSramRData   SRAM port
module mem_resp_multi #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic                           iCLK,
   input  logic                           iRST,
   input  logic                           iMemRead,
   input  logic                           iMemWrite,
   input  logic [31:0]                    iAddress,
   input  logic [31:0]                    iWriteData,
   input  logic [3:0]                     iByteEn,
   output logic [31:0]                    oReadData,
   output logic                           oReady,
   output logic                           oErr,
   output logic                           oBusy,
   output logic [$clog2(DEPTH_WORDS)-1:0] oSramAddr,
   output logic                           oSramWe,
   output logic [3:0]                     oSramBe,
   output logic [31:0]                    oSramWData,
   input  logic [31:0]                    iSramRData
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP,
      S_RELEASE
   } state_t;

   state_t         state, nextState;
   logic [3:0]     waitCnt;
   logic [AW-1:0]  wordAddrReg;
   logic [31:0]    dataReg;
   logic [3:0]     beReg;
   logic           writeReg;
   logic           errReg;
   logic [31:0]    readDataReg;

   logic [31:0]    byteOffset;
   logic           reqAny;
   logic           reqErr;

   // Addresses below ADDR_BASE wrap to a huge offset, so a single range
   // check covers both ends of the window.
   assign byteOffset = iAddress - ADDR_BASE;
   assign reqAny     = iMemRead | iMemWrite;
   assign reqErr     = (iMemRead & iMemWrite)
                     | (iAddress[1:0] != 2'b00)
                     | ((byteOffset >> (AW + 2)) != '0);

   // State register
   always_ff @(posedge iCLK) begin
      if (iRST) state <= S_IDLE;
      else      state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         S_IDLE: begin
            if (reqAny) begin
               if (reqErr)               nextState = S_RESP;
               else if (WAIT_CYCLES > 0) nextState = S_WAIT;
               else                      nextState = S_ACCESS;
            end
         end
         S_WAIT:    if (waitCnt == 4'd0) nextState = S_ACCESS;
         S_ACCESS:  nextState = S_RESP;
         S_RESP:    nextState = S_RELEASE;
         S_RELEASE: if (!reqAny) nextState = S_IDLE;
         default:   nextState = S_IDLE;
      endcase
   end

   // Request latches, wait counter and read-data register
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         waitCnt     <= '0;
         wordAddrReg <= '0;
         dataReg     <= '0;
         beReg       <= '0;
         writeReg    <= 1'b0;
         errReg      <= 1'b0;
         readDataReg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (reqAny) begin
                  wordAddrReg <= byteOffset[AW+1:2];
                  dataReg     <= iWriteData;
                  beReg       <= iByteEn;
                  writeReg    <= iMemWrite;
                  errReg      <= reqErr;
                  waitCnt     <= WAIT_LOAD;
               end
            end
            S_WAIT: if (waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
            // SRAM data for the ACCESS address is valid during RESP.
            S_RESP: if (!writeReg && !errReg) readDataReg <= iSramRData;
            default: ;
         endcase
      end
   end

   // Output logic. Strobes are masked by iRST so a reset landing in ACCESS
   // or RESP commits no write and produces no completion pulse.
   always_comb begin
      oReady  = 1'b0;
      oErr    = 1'b0;
      oSramWe = 1'b0;
      oSramBe = '0;
      oBusy   = (state != S_IDLE);
      case (state)
         S_ACCESS: begin
            if (writeReg) begin
               oSramWe = 1'b1;
               oSramBe = beReg;
            end
         end
         S_RESP: begin
            oReady = 1'b1;
            oErr   = errReg;
         end
         default: ;
      endcase
      if (iRST) begin
         oReady  = 1'b0;
         oErr    = 1'b0;
         oSramWe = 1'b0;
         oSramBe = '0;
      end
   end

   assign oSramAddr  = wordAddrReg;
   assign oSramWData = dataReg;
   assign oReadData  = readDataReg;

endmodule
